// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared constants and state encoding for the instruction loader
package inst_loader_pkg;

  localparam int INST_W       = 14;
  localparam int ADDR_W       = 5;
  localparam int DEPTH        = 2 ** ADDR_W;
  localparam int LEN_W        = ADDR_W + 1;
  localparam int DRAIN_CYCLES = 4;
  localparam int DRAIN_W      = 3;

  localparam logic [INST_W-1:0] NOP_INST = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/inst_loader_store.sv
// rtl/inst_loader_store.sv - DEPTH x INST_W instruction store, sync write, combinational read
// Reads at or beyond the loaded program length return NOP_INST.
module inst_store
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [INST_W-1:0] rdata_o
);

  logic [INST_W-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset; prog_len gates every read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = ({1'b0, raddr_i} < len_i) ? mem_q[raddr_i] : NOP_INST;

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - program load, core reset control and instruction issue for the 4-stage core
// FSM and counters live here; storage is in inst_store.
module inst_loader
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_last,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] instruction,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              pc_err
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]     prog_len_q, prog_len_d;
  logic [LEN_W-1:0]     issue_cnt_q, issue_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 core_rst_n_q, core_rst_n_d;
  logic                 pc_err_q, pc_err_d;
  logic                 store_we;
  logic [INST_W-1:0]    store_rdata;

  inst_store u_store (
    .clk     (clk),
    .we_i    (store_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (load_data),
    .raddr_i (pc),
    .len_i   (prog_len_q),
    .rdata_o (store_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      issue_cnt_q  <= '0;
      drain_cnt_q  <= '0;
      core_rst_n_q <= 1'b0;
      pc_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      issue_cnt_q  <= issue_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      pc_err_q     <= pc_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    issue_cnt_d  = issue_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    core_rst_n_d = core_rst_n_q;
    pc_err_d     = pc_err_q;
    store_we     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // run is meaningless here: nothing has been loaded since reset.
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end
      end

      ST_LOAD: begin
        if (load_valid) begin
          store_we = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (load_last || wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            prog_len_d = {1'b0, wr_ptr_q} + LEN_W'(1);
            state_d    = ST_ARMED;
          end
        end
      end

      ST_ARMED, ST_DONE: begin
        // A reload request takes priority over a simultaneous run.
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end else if (run) begin
          state_d      = ST_RUN;
          issue_cnt_d  = '0;
          core_rst_n_d = 1'b1;
        end
      end

      ST_RUN: begin
        issue_cnt_d = issue_cnt_q + LEN_W'(1);
        if (pc != issue_cnt_q[ADDR_W-1:0]) begin
          pc_err_d = 1'b1;
        end
        if (issue_cnt_q == prog_len_q - LEN_W'(1)) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_W'(DRAIN_CYCLES);
        end
      end

      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        if (drain_cnt_q == DRAIN_W'(1)) begin
          state_d      = ST_DONE;
          core_rst_n_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign load_ready  = (state_q == ST_LOAD);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign core_rst_n  = core_rst_n_q;
  assign pc_err      = pc_err_q;
  assign instruction = (state_q == ST_RUN) ? store_rdata : NOP_INST;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for inst_loader with a simple core pc model
// Expected instruction streams are queued by the stimulus and consumed by a monitor.
module tb_inst_loader;

  localparam logic [13:0] NOP = 14'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_valid, load_ready, load_last, run;
  logic [13:0] load_data, instruction;
  logic [4:0]  pc;
  logic        core_rst_n, busy, done, pc_err;

  int          vectors = 0;
  int          miscompares = 0;

  logic [13:0] sb[$];
  logic [13:0] wq[$];
  logic [13:0] prog[32];
  int          plen = 0;
  int          skip_at = -1;

  inst_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .run(run), .pc(pc), .instruction(instruction), .core_rst_n(core_rst_n),
    .busy(busy), .done(done), .pc_err(pc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model: pc restarts at 0 while held in reset, otherwise counts; skip_at forces a jump.
  initial begin
    logic rn;
    pc = '0;
    forever begin
      @(negedge clk) rn = core_rst_n;
      @(posedge clk) #1;
      if (rn === 1'b1)
        pc = pc + 5'd1 + (((int'(pc) + 1) == skip_at) ? 5'd1 : 5'd0);
      else
        pc = '0;
    end
  end

  // Monitor: every cycle the core is released consumes one expected instruction.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (core_rst_n === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: got instruction %h with no expected entry at %0t", instruction, $time);
        end else begin
          e = sb.pop_front();
          chk("instr_stream", {18'b0, instruction}, {18'b0, e});
        end
      end else begin
        chk("nop_while_held", {18'b0, instruction}, {18'b0, NOP});
      end
    end
  end

  task automatic step();
    @(posedge clk) #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    plen = 0;
  endtask

  // Expected stream: program words addressed by the modelled pc sequence, then the drain NOPs.
  function automatic void push_expected(int skip);
    int p;
    for (int i = 0; i < plen; i++) begin
      p = (skip >= 0 && i >= skip) ? i + 1 : i;
      sb.push_back((p < plen) ? prog[p] : NOP);
    end
    for (int i = 0; i < 4; i++) sb.push_back(NOP);
  endfunction

  task automatic do_load(input bit use_last, input bit toggle, input bit with_run);
    int n, exp_len, idx, cyc, accepted;
    bit acc, stop;
    n = wq.size();
    exp_len = (n > 32) ? 32 : n;
    load_start = 1'b1;
    run = with_run;
    load_valid = 1'b1;
    load_data = wq[0];
    load_last = use_last && (n == 1);
    @(negedge clk) chk("ready_on_start", {31'b0, load_ready}, 32'd0);
    step();
    load_start = 1'b0;
    run = 1'b0;
    if (with_run) begin
      chk("start_beats_run_busy", {31'b0, busy}, 32'd1);
      chk("start_beats_run_ready", {31'b0, load_ready}, 32'd1);
      chk("start_beats_run_rstn", {31'b0, core_rst_n}, 32'd0);
    end
    idx = 0; cyc = 0; accepted = 0; stop = 1'b0;
    while (idx < n && cyc < 200 && !stop) begin
      load_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      load_data = wq[idx];
      load_last = use_last && (idx == n - 1);
      @(negedge clk);
      acc = load_valid && load_ready;
      if (idx == 32) begin
        chk("ready_after_full", {31'b0, load_ready}, 32'd0);
        stop = 1'b1;
      end
      step();
      if (acc) begin
        idx++;
        accepted++;
      end
      cyc++;
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    chk("words_accepted", accepted, exp_len);
    chk("armed_not_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < exp_len; i++) prog[i] = wq[i];
    plen = exp_len;
  endtask

  task automatic do_run(input int skip, input logic exp_err);
    int n;
    skip_at = skip;
    push_expected(skip);
    run = 1'b1;
    step();
    run = 1'b0;
    chk("core_rstn_after_run", {31'b0, core_rst_n}, 32'd1);
    n = 1;
    while (!done && n < 200) begin
      step();
      n++;
    end
    chk("done_latency", n, plen + 5);
    chk("sb_drained", sb.size(), 0);
    chk("pc_err", {31'b0, pc_err}, {31'b0, exp_err});
    chk("done_core_held", {31'b0, core_rst_n}, 32'd0);
    chk("done_not_busy", {31'b0, busy}, 32'd0);
    sb.delete();
    skip_at = -1;
  endtask

  task automatic rand_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(14'($urandom));
  endtask

  initial begin
    rst = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    run = 1'b0; load_data = '0;
    do_reset();

    chk("rst_core_rstn", {31'b0, core_rst_n}, 32'd0);
    chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_pc_err", {31'b0, pc_err}, 32'd0);
    chk("rst_instr", {18'b0, instruction}, {18'b0, NOP});

    run = 1'b1; step(); run = 1'b0; step(); step();
    chk("idle_run_ignored_busy", {31'b0, busy}, 32'd0);
    chk("idle_run_ignored_rstn", {31'b0, core_rst_n}, 32'd0);

    // Directed three-word program, then re-execution from DONE.
    wq.delete();
    wq.push_back(14'h1A01); wq.push_back(14'h2B02); wq.push_back(14'h0C03);
    do_load(1'b1, 1'b0, 1'b0);
    do_run(-1, 1'b0);
    do_run(-1, 1'b0);

    // valid toggling every other cycle
    rand_words(3);
    do_load(1'b1, 1'b1, 1'b0);
    do_run(-1, 1'b0);

    // 33 words without last: store fills at 32
    rand_words(33);
    do_load(1'b0, 1'b0, 1'b0);
    do_run(-1, 1'b0);

    // pc skip: sticky through DONE and a clean re-run, cleared only by reset
    rand_words(5);
    do_load(1'b1, 1'b0, 1'b0);
    do_run(3, 1'b1);
    do_run(-1, 1'b1);
    do_reset();
    chk("pc_err_cleared", {31'b0, pc_err}, 32'd0);

    // reset in the middle of RUN
    rand_words(6);
    do_load(1'b1, 1'b0, 1'b0);
    push_expected(-1);
    run = 1'b1; step(); run = 1'b0;
    step();
    rst = 1'b0; step(); rst = 1'b1;
    plen = 0;
    sb.delete();
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_rstn", {31'b0, core_rst_n}, 32'd0);
    chk("abort_instr", {18'b0, instruction}, {18'b0, NOP});
    run = 1'b1; step(); run = 1'b0; step(); step();
    chk("abort_run_ignored_busy", {31'b0, busy}, 32'd0);
    chk("abort_run_ignored_rstn", {31'b0, core_rst_n}, 32'd0);

    // load_start and run together in DONE
    rand_words(3);
    do_load(1'b1, 1'b0, 1'b0);
    do_run(-1, 1'b0);
    rand_words(4);
    do_load(1'b1, 1'b0, 1'b1);
    do_run(-1, 1'b0);

    // randomized programs
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 32);
      rand_words(n);
      do_load(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      do_run(-1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
